// File: rtl/mem_fwd_mport.sv
// Multi-write-port register file with one forwarded read port, optional output stage and sequential clear.
// Highest-index write port wins on address collisions, and the same-cycle read sees that same winner.
module mem_fwd_mport #(
  parameter int WIDTH   = 4,
  parameter int ADDR_W  = 4,
  parameter int NWR     = 2,
  parameter int RD_PIPE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wa,
  input  logic [NWR*WIDTH-1:0]  wd,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     ra,
  output logic [WIDTH-1:0]      rd,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [WIDTH-1:0]    s1_q, s1_d;
  logic                v1_q, v1_d;
  logic [WIDTH-1:0]    rd_q, rd_d;
  logic                rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]    rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    s1_d       = s1_q;
    v1_d       = v1_q;
    rd_d       = rd_q;
    rd_valid_d = rd_valid_q;

    // Ascending scan, so the highest enabled port matching ra overrides the array.
    rdata = mem_q[ra];
    for (int i = 0; i < NWR; i++) begin
      if (we[i] && (wa[i*ADDR_W +: ADDR_W] == ra)) begin
        rdata = wd[i*WIDTH +: WIDTH];
      end
    end

    if (state_q == S_CLEAR) begin
      mem_d[cnt_q] = '0;
      cnt_d        = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = S_RUN;
      end
      v1_d       = 1'b0;
      rd_valid_d = 1'b0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i]) begin
          mem_d[wa[i*ADDR_W +: ADDR_W]] = wd[i*WIDTH +: WIDTH];
        end
      end
      if (clr) begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
      if (RD_PIPE != 0) begin
        if (re) begin
          s1_d = rdata;
        end
        v1_d       = re;
        rd_d       = s1_q;
        rd_valid_d = v1_q;
      end else begin
        if (re) begin
          rd_d = rdata;
        end
        rd_valid_d = re;
      end
    end
  end

  // The array is left untouched by reset; the clear engine zeroes it afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      s1_q       <= '0;
      v1_q       <= 1'b0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      s1_q       <= s1_d;
      v1_q       <= v1_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd       = rd_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == S_CLEAR);

endmodule

// File: tb/tb_mem_fwd_mport.sv
// Directed bench: one instance without and one with the output stage, driven by shared stimulus.
module tb_mem_fwd_mport;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [1:0] we;
  logic [7:0] wa;
  logic [7:0] wd;
  logic       re;
  logic [3:0] ra;

  logic [3:0] rd0, rd1;
  logic       rv0, rv1;
  logic       busy0, busy1;

  int checks = 0;
  int errors = 0;

  mem_fwd_mport #(.WIDTH(4), .ADDR_W(4), .NWR(2), .RD_PIPE(0)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd0), .rd_valid(rv0), .busy(busy0)
  );

  mem_fwd_mport #(.WIDTH(4), .ADDR_W(4), .NWR(2), .RD_PIPE(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd1), .rd_valid(rv1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we  = 2'b00;
    re  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic wr0(input logic [3:0] a, input logic [3:0] d);
    we     = 2'b01;
    wa     = {4'h0, a};
    wd     = {4'h0, d};
    re     = 1'b0;
    step();
    idle();
  endtask

  // Single read: checks the unpipelined result, then the pipelined one a cycle later.
  task automatic rd_chk(input logic [3:0] a, input logic [3:0] exp);
    we = 2'b00;
    re = 1'b1;
    ra = a;
    step();
    re = 1'b0;
    chk("rd0", 32'(rd0), 32'(exp));
    chk("rv0", 32'(rv0), 32'd1);
    step();
    chk("rd1", 32'(rd1), 32'(exp));
    chk("rv1", 32'(rv1), 32'd1);
    chk("rv0_pulse", 32'(rv0), 32'd0);
  endtask

  task automatic count_busy(output int n, output int vcnt);
    n    = 0;
    vcnt = 0;
    while (busy0 && n < 40) begin
      if (rv0 || rv1) vcnt++;
      step();
      n++;
    end
  endtask

  int n, vcnt;

  initial begin
    rst = 1'b1; clr = 1'b0; we = '0; wa = '0; wd = '0; re = 1'b0; ra = '0;

    // Reset and initial clear
    step();
    step();
    chk("rst_rd0", 32'(rd0), 32'd0);
    chk("rst_rv0", 32'(rv0), 32'd0);
    chk("rst_rd1", 32'(rd1), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd1);
    rst = 1'b0;
    count_busy(n, vcnt);
    chk("rst_busy_len", 32'(n), 32'd16);
    chk("rst_busy1", 32'(busy1), 32'd0);
    for (int a = 0; a < 16; a++) rd_chk(4'(a), 4'h0);

    // Same-address collision with same-cycle read
    we = 2'b11; wa = {4'h5, 4'h5}; wd = {4'hC, 4'hA}; re = 1'b1; ra = 4'h5;
    step();
    idle();
    chk("fwd_rd0", 32'(rd0), 32'hC);
    chk("fwd_rv0", 32'(rv0), 32'd1);
    step();
    chk("fwd_rd1", 32'(rd1), 32'hC);
    rd_chk(4'h5, 4'hC);

    // Edge addresses written while an unrelated word is read
    wr0(4'h1, 4'h9);
    we = 2'b11; wa = {4'h0, 4'hF}; wd = {4'h7, 4'h3}; re = 1'b1; ra = 4'h1;
    step();
    idle();
    chk("wrap_rd0", 32'(rd0), 32'h9);
    step();
    chk("wrap_rd1", 32'(rd1), 32'h9);
    rd_chk(4'hF, 4'h3);
    rd_chk(4'h0, 4'h7);

    // Back-to-back reads, then re=0 holds rd
    re = 1'b1; ra = 4'hF;
    step();
    chk("b2b_rd0_a", 32'(rd0), 32'h3);
    ra = 4'h0;
    step();
    chk("b2b_rd0_b", 32'(rd0), 32'h7);
    chk("b2b_rd1_a", 32'(rd1), 32'h3);
    re = 1'b0;
    step();
    chk("b2b_rd1_b", 32'(rd1), 32'h7);
    chk("b2b_rv1", 32'(rv1), 32'd1);
    chk("hold_rd0", 32'(rd0), 32'h7);
    chk("hold_rv0", 32'(rv0), 32'd0);

    // In-flight pipelined read must not see a later write
    wr0(4'h2, 4'h1);
    re = 1'b1; ra = 4'h2;
    step();
    re = 1'b0; we = 2'b01; wa = {4'h0, 4'h2}; wd = {4'h0, 4'h6};
    chk("iso_rd0", 32'(rd0), 32'h1);
    step();
    idle();
    chk("iso_rd1", 32'(rd1), 32'h1);
    chk("iso_rv1", 32'(rv1), 32'd1);
    rd_chk(4'h2, 4'h6);

    // Clear issued alongside a write, reads attempted while busy
    for (int a = 0; a < 16; a++) wr0(4'(a), 4'(a + 1));
    rd_chk(4'h1, 4'h2);
    clr = 1'b1; we = 2'b01; wa = {4'h0, 4'h3}; wd = {4'h0, 4'h4};
    step();
    idle();
    re = 1'b1; ra = 4'h3;
    count_busy(n, vcnt);
    re = 1'b0;
    chk("clr_busy_len", 32'(n), 32'd16);
    chk("clr_rv_busy", 32'(vcnt), 32'd0);
    chk("clr_rd_hold", 32'(rd0), 32'h2);
    rd_chk(4'h3, 4'h0);
    rd_chk(4'hE, 4'h0);

    // Reset in the middle of a clear restarts the sweep
    for (int a = 0; a < 16; a++) wr0(4'(a), 4'(15 - a));
    rd_chk(4'h4, 4'hB);
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("mid_busy", 32'(busy0), 32'd1);
    chk("mid_rd_hold", 32'(rd0), 32'hB);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_rd0", 32'(rd0), 32'd0);
    chk("mid_rst_rd1", 32'(rd1), 32'd0);
    count_busy(n, vcnt);
    chk("mid_busy_len", 32'(n), 32'd16);
    for (int a = 0; a < 16; a++) rd_chk(4'(a), 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_fwd_mport.md
# mem_fwd_mport

Parametrised multi-write-port register-file memory with one read port, priority write-collision resolution, write-to-read forwarding, an optional output pipeline stage and a built-in sequential clear engine. It replaces hand-coded fixed-width two-writer memories in the opt regression set and serves as the generic small-RAM building block for datapath register files.

## Interface
- WIDTH, 4: data width in bits.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W words.
- NWR, 2: number of write ports (1..4).
- RD_PIPE, 0: 0 = single-register read, 1 = extra output register.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  pulse: start a memory clear (ignored while busy).
- we  in  NWR  write enables; bit i belongs to port i.
- wa  in  NWR*ADDR_W  write addresses; port i at [i*ADDR_W +: ADDR_W].
- wd  in  NWR*WIDTH  write data; port i at [i*WIDTH +: WIDTH].
- re  in  1  read enable.
- ra  in  ADDR_W  read address.
- rd  out  WIDTH  read data, registered.
- rd_valid  out  1  rd holds the result of an accepted read.
- busy  out  1  clear engine active; writes/reads ignored.

## Operation
- FSM states: CLEAR, RUN.
- rst=1 at an edge: state<=CLEAR, clear counter<=0, rd<=0, rd_valid<=0, pipeline register<=0. busy=1 while state==CLEAR (combinational from state).
- CLEAR: each cycle writes 0 to mem[counter], counter++. On the cycle counter==DEPTH-1: write, then state<=RUN. Takes exactly DEPTH cycles. we/re/clr are ignored. rd_valid is forced to 0 and rd holds its value.
- RUN, clr=1: state<=CLEAR, counter<=0. Writes and reads presented in that same cycle are still performed.
- Write: for every i with we[i], mem[wa[i]]<=wd[i]. If several enabled ports share an address, the highest index i wins.
- Read (re=1 in RUN): data = mem[ra] as of before this edge, overridden by wd[i] of the highest-index enabled port with wa[i]==ra (same priority as the write). re=0 leaves rd unchanged.
- RD_PIPE=0: rd<=data, rd_valid<=re.
- RD_PIPE=1: stage register s1<=data and v1<=re; then rd<=s1, rd_valid<=v1. Writes after the read's sampling edge never alter a value already in flight.
- All address arithmetic wraps modulo DEPTH. No out-of-range addresses exist.
- rst has priority over clr and over all writes. A reset mid-clear restarts at address 0.

## Timing
- Read latency: 1 cycle (RD_PIPE=0) or 2 cycles (RD_PIPE=1) from the edge sampling re=1. Throughput is one read per cycle.
- Write visible to a read in the same cycle via forwarding. It is visible via the array from the next cycle.
- busy rises at the edge sampling rst or clr and falls DEPTH edges later. First accepted access is in the cycle busy is low.
- rd_valid is a one-cycle pulse per accepted read. It is not sticky.

## Test plan
- Reset: hold rst 2 cycles, release. busy=1 for exactly 16 cycles (ADDR_W=4), rd=0, rd_valid=0. Reading every address afterwards returns 0.
- Forwarding: RD_PIPE=0, NWR=2, we=2'b11, wa0=5, wd0=4'hA, wa1=5, wd1=4'hC, re=1, ra=5 in one cycle. Next cycle rd=4'hC, rd_valid=1. A later read of 5 returns 4'hC.
- Wrap-around: wa0=4'hF, wd0=3, wa1=4'h0, wd1=7, ra=4'h1 with mem[1]=9 preloaded. Expect rd=9. Next, reading 4'hF gives 3 and reading 0 gives 7.
- Pipeline isolation: RD_PIPE=1, read ra=2 (mem[2]=1), then write mem[2]=6 the next cycle. rd=1 with rd_valid two cycles after the read. A subsequent read returns 6.
- Clear mid-traffic: fill memory, pulse clr with we0=1, wa0=3, wd0=4. busy=1 for 16 cycles, re ignored (rd_valid=0). Afterwards mem[3]=0.
- Reset mid-clear: assert rst at clear cycle 7. busy stays high for 16 full cycles after rst release. All words read 0.
